// File: rtl/snes_port_ctrl.sv
// SNES controller-port server: arbitrates among button, PS/2 and IR sources,
// snapshots the owner's 16-bit state on console latch and shifts it out per console clock.
module snes_port_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 208000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] button_data,
  input  logic [15:0] keyboard_data,
  input  logic [15:0] ir_data,
  input  logic [1:0]  mode,
  input  logic        snes_latch,
  input  logic        snes_clk,
  output logic        snes_data,
  output logic [1:0]  active_src,
  output logic        frame_done
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(HOLD_CYCLES);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [SYNC_STAGES-1:0] latch_sync_q, sclk_sync_q;
  logic                   latch_prev_q, sclk_prev_q;
  logic                   latch_s, sclk_s, latch_rise, sclk_rise;

  logic [1:0]        owner_q, owner_d, prio_src;
  logic [1:0]        mode_q;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [2:0]        src_act;
  logic              owner_act;
  logic [15:0]       owner_data;

  logic [1:0]  state_q, state_d;
  logic [15:0] sr_q, sr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        cmp_q, cmp_d;
  logic        sdata_q;

  assign latch_s    = latch_sync_q[SYNC_STAGES-1];
  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign latch_rise = latch_s & ~latch_prev_q;
  assign sclk_rise  = sclk_s & ~sclk_prev_q;

  assign snes_data  = sdata_q;
  assign active_src = owner_q;
  assign frame_done = done_q;

  always_comb begin
    src_act = {(ir_data != 16'h0), (keyboard_data != 16'h0), (button_data != 16'h0)};
    case (owner_q)
      2'b00:   begin owner_act = src_act[0]; owner_data = button_data;   end
      2'b01:   begin owner_act = src_act[1]; owner_data = keyboard_data; end
      2'b10:   begin owner_act = src_act[2]; owner_data = ir_data;       end
      default: begin owner_act = 1'b0;       owner_data = 16'h0;         end
    endcase
    if (src_act[0])      prio_src = 2'b00;
    else if (src_act[1]) prio_src = 2'b01;
    else                 prio_src = 2'b10;
  end

  // Ownership: forced modes pin the owner; auto mode holds the owner until it idles out.
  always_comb begin
    owner_d = owner_q;
    hold_d  = hold_q;
    if (mode != 2'b00) begin
      owner_d = mode - 2'd1;
      hold_d  = '0;
    end else if (mode_q != 2'b00) begin
      owner_d = mode_q - 2'd1;
      hold_d  = HOLD_LD;
    end else if (owner_act) begin
      hold_d = HOLD_LD;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
    end else if (|src_act) begin
      owner_d = prio_src;
      hold_d  = HOLD_LD;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    cmp_d   = cmp_q;
    if (latch_rise) begin
      state_d = ST_LOAD;
      cmp_d   = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          sr_d  = owner_data;
          cnt_d = 5'd0;
          if (!latch_s) state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (sclk_rise) begin
            sr_d  = {1'b0, sr_q[15:1]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd15) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              cmp_d   = 1'b1;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Output is registered from sr_q so a console clock edge reaches the pin SYNC_STAGES+2 clocks later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latch_sync_q <= '0;
      sclk_sync_q  <= '0;
      latch_prev_q <= 1'b0;
      sclk_prev_q  <= 1'b0;
      owner_q      <= 2'b00;
      mode_q       <= 2'b00;
      hold_q       <= '0;
      state_q      <= ST_IDLE;
      sr_q         <= 16'h0;
      cnt_q        <= 5'd0;
      done_q       <= 1'b0;
      cmp_q        <= 1'b0;
      sdata_q      <= 1'b1;
    end else begin
      latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], snes_latch};
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], snes_clk};
      latch_prev_q <= latch_s;
      sclk_prev_q  <= sclk_s;
      owner_q      <= owner_d;
      mode_q       <= mode;
      hold_q       <= hold_d;
      state_q      <= state_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      cmp_q        <= cmp_d;
      sdata_q      <= cmp_q ? 1'b0 : ~sr_q[0];
    end
  end

endmodule

// File: tb/tb_snes_port_ctrl.sv
// Bench for snes_port_ctrl: serial bits checked through an expected-bit queue,
// arbitration and reset behaviour checked directly.
module tb_snes_port_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] button_data, keyboard_data, ir_data;
  logic [1:0]  mode;
  logic        snes_latch, snes_clk;
  logic        snes_data;
  logic [1:0]  active_src;
  logic        frame_done;

  int n_cmp = 0;
  int n_err = 0;
  int fd_cnt = 0;
  logic exp_q[$];

  snes_port_ctrl #(.SYNC_STAGES(2), .HOLD_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n),
    .button_data(button_data), .keyboard_data(keyboard_data), .ir_data(ir_data),
    .mode(mode), .snes_latch(snes_latch), .snes_clk(snes_clk),
    .snes_data(snes_data), .active_src(active_src), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) fd_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sample_bit(input string tag);
    logic e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {31'd0, snes_data}, {31'd0, e});
    end
  endtask

  task automatic run_frame(input logic [15:0] d, input int nshift, input bit glitch);
    int fd0;
    fd0 = fd_cnt;
    snes_latch = 1'b1;
    cyc(5);
    if (glitch) begin
      repeat (2) begin
        snes_clk = 1'b0; cyc(3);
        snes_clk = 1'b1; cyc(3);
      end
    end
    cyc(3);
    snes_latch = 1'b0;
    cyc(8);
    for (int i = 0; i < nshift; i++) begin
      exp_q.push_back(~d[i]);
      sample_bit("serial_bit");
      snes_clk = 1'b0; cyc(6);
      snes_clk = 1'b1; cyc(6);
    end
    if (nshift == 16) begin
      exp_q.push_back(1'b0);
      sample_bit("post_frame_low");
      chk("frame_done_count", fd_cnt, fd0 + 1);
    end else begin
      chk("no_frame_done", fd_cnt, fd0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    button_data = '0; keyboard_data = '0; ir_data = '0;
    mode = 2'b00;
    snes_latch = 1'b0; snes_clk = 1'b1;
    cyc(2);
    chk("reset_snes_data", {31'd0, snes_data}, 32'd1);
    chk("reset_active_src", {30'd0, active_src}, 32'd0);
    chk("reset_frame_done", {31'd0, frame_done}, 32'd0);
    reset_n = 1'b1;
    cyc(2);

    // Forced keyboard frame: B and A pressed.
    mode = 2'b10; keyboard_data = 16'h0101;
    cyc(2);
    chk("forced_kbd_src", {30'd0, active_src}, 32'd1);
    run_frame(16'h0101, 16, 1'b0);

    // Auto priority: keyboard owner idles out, then IR and button appear together.
    keyboard_data = 16'h0;
    mode = 2'b00;
    cyc(14);
    chk("auto_idle_keeps_owner", {30'd0, active_src}, 32'd1);
    ir_data = 16'h0010; button_data = 16'h0001;
    cyc(1);
    chk("auto_priority_button", {30'd0, active_src}, 32'd0);

    // Hold timeout: keyboard owner goes idle while IR is active.
    ir_data = 16'h0; button_data = 16'h0;
    mode = 2'b10; keyboard_data = 16'h0004;
    cyc(2);
    mode = 2'b00;
    cyc(3);
    chk("hold_owner_kbd", {30'd0, active_src}, 32'd1);
    keyboard_data = 16'h0; ir_data = 16'h0008;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      chk($sformatf("hold_cycle_%0d", k), {30'd0, active_src}, 32'd1);
    end
    cyc(1);
    chk("hold_expired_ir", {30'd0, active_src}, 32'd2);

    // Latch abort: partial frame, then a fresh frame restarts the count.
    ir_data = 16'h0;
    mode = 2'b01; button_data = 16'h00F3;
    cyc(2);
    chk("forced_button_src", {30'd0, active_src}, 32'd0);
    run_frame(16'h00F3, 5, 1'b0);
    button_data = 16'h8000;
    run_frame(16'h8000, 16, 1'b0);

    // Console clock pulses in IDLE and during latch must not shift.
    repeat (2) begin
      snes_clk = 1'b0; cyc(3);
      snes_clk = 1'b1; cyc(3);
    end
    chk("idle_pulses_data_low", {31'd0, snes_data}, 32'd0);
    button_data = 16'h5A3C;
    run_frame(16'h5A3C, 16, 1'b1);

    // Reset mid-frame.
    mode = 2'b10; keyboard_data = 16'h1234;
    cyc(2);
    run_frame(16'h1234, 8, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midreset_snes_data", {31'd0, snes_data}, 32'd1);
    chk("midreset_active_src", {30'd0, active_src}, 32'd0);
    chk("midreset_frame_done", {31'd0, frame_done}, 32'd0);
    cyc(3);
    reset_n = 1'b1;
    cyc(2);
    chk("postreset_kbd_src", {30'd0, active_src}, 32'd1);
    run_frame(16'h1234, 16, 1'b0);

    cyc(4);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
